ale_alu: RTL and testbench
==========================

// Module: ale_alu
// PURPOSE
//  Parameterised N-bit arithmetic/logic unit for the datapath.
//  Executes one of 11 operations on operands a and b, selected by a 4-bit opcode.
//  Result and status flags are registered, with one cycle of latency.
//  Sits between the register-file read ports and the writeback mux.
// PARAMETERS
//  N  default 4  operand/result width in bits (N >= 2)
// PORTS
//  clk         in   1    single clock; all state updates on rising edge
//  rst         in   1    synchronous, active-high reset
//  a           in   N    operand A (unsigned unless noted)
//  b           in   N    operand B / shift amount
//  alu_select  in   4    opcode
//  result      out  N    registered result
//  flags       out  4    registered {Nf,Z,C,V}
// BEHAVIOUR
//  - Reset: on a rising clk edge with rst=1, result<=0 and flags<=0.
//    rst has priority over any opcode, including mid-sequence.
//  - Latency: inputs sampled at edge k appear on result/flags after edge k. No handshake.
//    A new op is accepted every cycle.
//  - Opcodes (r = N-bit result):
//    0 MOV  r=a; C=V=0
//    1 ADD  r=a+b mod 2^N; C=carry-out; V=signed overflow
//    2 SUB  r=a-b mod 2^N; C=borrow (a<b unsigned); V=signed overflow
//    3 MUL  r=low N bits of a*b (unsigned); C=V=(upper N bits of 2N product !=0)
//    4 DIV  r=a/b unsigned, truncating, remainder discarded; C=0, V=0
//           b==0: r=all ones, V=1
//    5 XOR  r=a^b; C=V=0
//    6 AND  r=a&b; C=V=0
//    7 NOT  r=~a (b ignored); C=V=0
//    8 SHL  r=a<<b, zero fill; C=1 if any 1 bit shifted out; V=0
//    9 SHR  r=a>>b logical, zero fill; C=1 if any 1 bit shifted out; V=0
//    10 CMP flags from a-b exactly as SUB; result register holds its previous value
//    11-15  r=0, all flags 0
//  - Shift amount b is unsigned. b>=N gives r=0, with C=|a.
//  - Nf = r[N-1] and Z = (r==0) for every opcode except CMP and 11-15.
//    For CMP, Nf and Z come from the a-b difference.
//  - All arithmetic is computed combinationally at full width (N+1 or 2N bits),
//    then truncated into the registers.
// TESTING
//  - Reset: rst=1 for 2 cycles with any inputs -> result=0, flags=0.
//    Assert rst mid-sweep -> zeroed on the next edge.
//  - N=4, a=4, b=2, sweep opcode 0..10 one per cycle; result one cycle later:
//    MOV=4, ADD=6, SUB=2, MUL=8, DIV=2, XOR=6, AND=0 (Z=1), NOT=11 (Nf=1),
//    SHL=0 (Z=1, C=1), SHR=1, CMP holds 1 with C=0, Z=0.
//  - ADD edge cases:
//    a=15, b=1 -> r=0, C=1, Z=1, V=0.
//    a=7, b=1 -> r=8, V=1, Nf=1, C=0.
//  - SUB/CMP: a=2, b=4 -> SUB r=14, C=1, Nf=1.
//    CMP with a=b=5 -> Z=1, result unchanged.
//  - MUL/DIV: a=5, b=4 -> MUL r=4, C=V=1.
//    a=9, b=0 DIV -> r=15, V=1.
//    a=9, b=2 DIV -> r=4.
//  - Opcodes 11..15 with a=15, b=15 -> r=0, flags=0.
//    Back-to-back opcode changes every cycle produce no bubbles.

Source files
------------

// File: rtl/ale_alu_if.sv
// Operand, opcode and result/flag bundle between the register file, ALU and writeback mux.
interface ale_alu_if #(
    parameter int N = 4
);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   alu_select;
    logic [N-1:0] result;
    logic [3:0]   flags;

    modport master (
        output a,
        output b,
        output alu_select,
        input  result,
        input  flags
    );

    modport slave (
        input  a,
        input  b,
        input  alu_select,
        output result,
        output flags
    );
endinterface

// File: rtl/ale_alu.sv
// N-bit ALU with 11 opcodes; result and {Nf,Z,C,V} flags are registered with one cycle of latency.
module ale_alu #(
    parameter int N = 4
) (
    input logic    clk,
    input logic    rst,
    ale_alu_if.slave bus
);

    typedef enum logic [3:0] {
        OP_MOV = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_MUL = 4'd3,
        OP_DIV = 4'd4,
        OP_XOR = 4'd5,
        OP_AND = 4'd6,
        OP_NOT = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_CMP = 4'd10
    } aluOp_e;

    typedef enum logic [1:0] {
        FLAGS_FROM_RESULT,
        FLAGS_FROM_DIFF,
        FLAGS_CLEAR
    } flagSrc_e;

    localparam logic [N-1:0] SHIFT_LIMIT = N[N-1:0];

    logic [N-1:0]   result_q, result_d;
    logic [3:0]     flags_q, flags_d;

    logic [N:0]     sumFull;
    logic [N:0]     diffFull;
    logic [2*N-1:0] prodFull;
    logic [2*N-1:0] shlWide;
    logic [2*N-1:0] shrWide;
    logic [N-1:0]   divisor;
    logic [N-1:0]   quotient;
    logic           shiftOver;
    logic           addOverflow;
    logic           subOverflow;
    logic           carry;
    logic           overflow;
    flagSrc_e       flagSrc;

    // Full-width datapath results; each opcode picks and truncates what it needs.
    always_comb begin
        sumFull     = {1'b0, bus.a} + {1'b0, bus.b};
        diffFull    = {1'b0, bus.a} - {1'b0, bus.b};
        prodFull    = {{N{1'b0}}, bus.a} * {{N{1'b0}}, bus.b};
        divisor     = (bus.b == '0) ? {{(N-1){1'b0}}, 1'b1} : bus.b;
        quotient    = bus.a / divisor;
        shiftOver   = (bus.b >= SHIFT_LIMIT);
        shlWide     = {{N{1'b0}}, bus.a} << bus.b;
        shrWide     = {bus.a, {N{1'b0}}} >> bus.b;
        addOverflow = (bus.a[N-1] == bus.b[N-1]) && (sumFull[N-1] != bus.a[N-1]);
        subOverflow = (bus.a[N-1] != bus.b[N-1]) && (diffFull[N-1] != bus.a[N-1]);
    end

    always_comb begin
        result_d = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        flagSrc  = FLAGS_FROM_RESULT;
        flags_d  = '0;

        case (bus.alu_select)
            OP_MOV: result_d = bus.a;
            OP_ADD: begin
                result_d = sumFull[N-1:0];
                carry    = sumFull[N];
                overflow = addOverflow;
            end
            OP_SUB: begin
                result_d = diffFull[N-1:0];
                carry    = diffFull[N];
                overflow = subOverflow;
            end
            OP_MUL: begin
                result_d = prodFull[N-1:0];
                carry    = |prodFull[2*N-1:N];
                overflow = |prodFull[2*N-1:N];
            end
            OP_DIV: begin
                if (bus.b == '0) begin
                    result_d = '1;
                    overflow = 1'b1;
                end else begin
                    result_d = quotient;
                end
            end
            OP_XOR: result_d = bus.a ^ bus.b;
            OP_AND: result_d = bus.a & bus.b;
            OP_NOT: result_d = ~bus.a;
            // Oversized shift amounts flush every operand bit out of the word.
            OP_SHL: begin
                if (shiftOver) begin
                    carry = |bus.a;
                end else begin
                    result_d = shlWide[N-1:0];
                    carry    = |shlWide[2*N-1:N];
                end
            end
            OP_SHR: begin
                if (shiftOver) begin
                    carry = |bus.a;
                end else begin
                    result_d = shrWide[2*N-1:N];
                    carry    = |shrWide[N-1:0];
                end
            end
            OP_CMP: begin
                result_d = result_q;
                flagSrc  = FLAGS_FROM_DIFF;
            end
            default: flagSrc = FLAGS_CLEAR;
        endcase

        case (flagSrc)
            FLAGS_FROM_RESULT: flags_d = {result_d[N-1], (result_d == '0), carry, overflow};
            FLAGS_FROM_DIFF:   flags_d = {diffFull[N-1], (diffFull[N-1:0] == '0), diffFull[N], subOverflow};
            default:           flags_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.result = result_q;
    assign bus.flags  = flags_q;

endmodule

// File: tb/tb_ale_alu.sv
// Directed-vector scoreboard bench for ale_alu at N=4; flags are {Nf,Z,C,V}.
module tb_ale_alu;

   typedef struct {
      string      name;
      logic [3:0] result;
      logic [3:0] flags;
   } expect_t;

   logic clk;
   logic rst;
   int   vectorCount;
   int   missCount;
   expect_t scoreboard[$];

   ale_alu_if #(.N(4)) bus ();

   ale_alu #(.N(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one vector on the falling edge and queues the response expected after the next rising edge.
   task automatic applyStimulus(input logic r, input logic [3:0] op, input logic [3:0] a,
                                input logic [3:0] b, input logic [3:0] expResult,
                                input logic [3:0] expFlags, input string name);
      expect_t e;
      @(negedge clk);
      rst            = r;
      bus.alu_select = op;
      bus.a          = a;
      bus.b          = b;
      e.name   = name;
      e.result = expResult;
      e.flags  = expFlags;
      scoreboard.push_back(e);
   endtask

   // Compares the registered outputs against one scoreboard entry.
   task automatic checkOutput(input expect_t e);
      vectorCount++;
      if (bus.result !== e.result || bus.flags !== e.flags) begin
         missCount++;
         $display("[TB] FAIL %s: got result=%0d flags=%b, expected result=%0d flags=%b",
                  e.name, bus.result, bus.flags, e.result, e.flags);
      end
   endtask

   // Monitor: every rising edge, the DUT presents the response to whatever was queued before it.
   initial begin
      expect_t e;
      forever begin
         @(posedge clk);
         #1;
         if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkOutput(e);
         end
      end
   end

   // Stimulus sequence; flags column is {Nf,Z,C,V}.
   initial begin
      int drainCycles;
      vectorCount    = 0;
      missCount      = 0;
      rst            = 1'b1;
      bus.a          = 4'd0;
      bus.b          = 4'd0;
      bus.alu_select = 4'd0;

      applyStimulus(1'b1, 4'd1, 4'd9,  4'd3, 4'd0, 4'b0000, "reset0");
      applyStimulus(1'b1, 4'd3, 4'd15, 4'd7, 4'd0, 4'b0000, "reset1");

      applyStimulus(1'b0, 4'd0,  4'd4, 4'd2, 4'd4,  4'b0000, "sweepMOV");
      applyStimulus(1'b0, 4'd1,  4'd4, 4'd2, 4'd6,  4'b0000, "sweepADD");
      applyStimulus(1'b0, 4'd2,  4'd4, 4'd2, 4'd2,  4'b0000, "sweepSUB");
      applyStimulus(1'b0, 4'd3,  4'd4, 4'd2, 4'd8,  4'b1000, "sweepMUL");
      applyStimulus(1'b0, 4'd4,  4'd4, 4'd2, 4'd2,  4'b0000, "sweepDIV");
      applyStimulus(1'b0, 4'd5,  4'd4, 4'd2, 4'd6,  4'b0000, "sweepXOR");
      applyStimulus(1'b0, 4'd6,  4'd4, 4'd2, 4'd0,  4'b0100, "sweepAND");
      applyStimulus(1'b0, 4'd7,  4'd4, 4'd2, 4'd11, 4'b1000, "sweepNOT");
      applyStimulus(1'b0, 4'd8,  4'd4, 4'd2, 4'd0,  4'b0110, "sweepSHL");
      applyStimulus(1'b0, 4'd9,  4'd4, 4'd2, 4'd1,  4'b0000, "sweepSHR");
      applyStimulus(1'b0, 4'd10, 4'd4, 4'd2, 4'd1,  4'b0000, "sweepCMP");

      applyStimulus(1'b1, 4'd1,  4'd15, 4'd1, 4'd0, 4'b0000, "midReset");
      applyStimulus(1'b0, 4'd10, 4'd3,  4'd1, 4'd0, 4'b0000, "cmpAfterReset");

      applyStimulus(1'b0, 4'd1, 4'd15, 4'd1, 4'd0,  4'b0110, "addWrap");
      applyStimulus(1'b0, 4'd1, 4'd7,  4'd1, 4'd8,  4'b1001, "addOverflow");
      applyStimulus(1'b0, 4'd2, 4'd2,  4'd4, 4'd14, 4'b1010, "subBorrow");
      applyStimulus(1'b0, 4'd10, 4'd5, 4'd5, 4'd14, 4'b0100, "cmpEqual");
      applyStimulus(1'b0, 4'd2, 4'd8,  4'd1, 4'd7,  4'b0001, "subOverflow");
      applyStimulus(1'b0, 4'd3, 4'd5,  4'd4, 4'd4,  4'b0011, "mulOverflow");
      applyStimulus(1'b0, 4'd4, 4'd9,  4'd0, 4'd15, 4'b1001, "divByZero");
      applyStimulus(1'b0, 4'd4, 4'd9,  4'd2, 4'd4,  4'b0000, "divTrunc");

      applyStimulus(1'b0, 4'd8, 4'd3,  4'd3, 4'd8,  4'b1010, "shlCarry");
      applyStimulus(1'b0, 4'd8, 4'd5,  4'd4, 4'd0,  4'b0110, "shlOversize");
      applyStimulus(1'b0, 4'd9, 4'd6,  4'd1, 4'd3,  4'b0000, "shrClean");
      applyStimulus(1'b0, 4'd9, 4'd7,  4'd1, 4'd3,  4'b0010, "shrCarry");
      applyStimulus(1'b0, 4'd9, 4'd8,  4'd7, 4'd0,  4'b0110, "shrOversize");
      applyStimulus(1'b0, 4'd9, 4'd0,  4'd9, 4'd0,  4'b0100, "shrZeroOversize");

      applyStimulus(1'b0, 4'd0,  4'd9,  4'd0,  4'd9, 4'b1000, "movBeforeIllegal");
      applyStimulus(1'b0, 4'd11, 4'd15, 4'd15, 4'd0, 4'b0000, "op11");
      applyStimulus(1'b0, 4'd12, 4'd15, 4'd15, 4'd0, 4'b0000, "op12");
      applyStimulus(1'b0, 4'd13, 4'd15, 4'd15, 4'd0, 4'b0000, "op13");
      applyStimulus(1'b0, 4'd14, 4'd15, 4'd15, 4'd0, 4'b0000, "op14");
      applyStimulus(1'b0, 4'd15, 4'd15, 4'd15, 4'd0, 4'b0000, "op15");

      drainCycles = 0;
      while (scoreboard.size() > 0 && drainCycles < 10) begin
         @(negedge clk);
         drainCycles++;
      end
      if (scoreboard.size() > 0) begin
         missCount++;
         $display("[TB] FAIL drain: %0d responses outstanding, expected 0", scoreboard.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
